// File: rtl/iomem_timer_pkg.sv
// Shared register map and bit positions for the iomem timer peripheral.
package iomem_timer_pkg;

  // Register offsets inside the 256-byte window (addr[1:0] ignored).
  localparam logic [7:0] TMR_CTRL     = 8'h00;
  localparam logic [7:0] TMR_PRESCALE = 8'h04;
  localparam logic [7:0] TMR_LOAD     = 8'h08;
  localparam logic [7:0] TMR_COUNT    = 8'h0C;
  localparam logic [7:0] TMR_STATUS   = 8'h10;

  // CTRL bit indices.
  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_AR = 1;
  localparam int unsigned CTRL_IE = 2;

  // STATUS bit indices.
  localparam int unsigned STATUS_EXP = 0;

  // Merge write data into an existing word, honouring each byte strobe.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wstrb[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// Programmable prescaler: emits a one-cycle tick every (div+1) enabled cycles.
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] pcnt;

  assign tick = en & (pcnt == div);

  // Prescale counter: held at 0 while disabled or cleared, wraps on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!en || clr) begin
      pcnt <= '0;
    end else if (pcnt == div) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/iomem_timer.sv
// 32-bit down-counting timer on the iomem bus with prescaler, auto-reload,
// sticky expiry flag and registered level interrupt.
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
  parameter logic [15:0] RESET_PRESCALE = 16'h0000,
  parameter logic [31:0] RESET_LOAD     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  logic        en, ar, ie, exp;
  logic [15:0] prescale;
  logic [31:0] load, count;

  logic        hit, sel, wr, rd, tick, expire, pclr;
  logic [7:0]  off;
  logic [31:0] rd_val, wd_prescale, wd_load, wd_count;
  logic        unused_bits;

  assign off    = {iomem_addr[7:2], 2'b00};
  assign hit    = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign sel    = iomem_valid & hit & ~iomem_ready;
  assign wr     = sel & (|iomem_wstrb);
  assign rd     = sel & ~(|iomem_wstrb);
  assign expire = tick & (count == '0);

  assign wd_prescale = apply_wstrb({16'h0000, prescale}, iomem_wdata, iomem_wstrb);
  assign wd_load     = apply_wstrb(load, iomem_wdata, iomem_wstrb);
  assign wd_count    = apply_wstrb(count, iomem_wdata, iomem_wstrb);

  // Prescaler restarts from zero when a CTRL write turns EN on.
  assign pclr = wr & (off == TMR_CTRL) & iomem_wstrb[0] & iomem_wdata[CTRL_EN] & ~en;

  assign unused_bits = &{1'b0, iomem_addr[1:0], wd_prescale[31:16]};

  timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (pclr),
    .div  (prescale),
    .tick (tick)
  );

  // Read mux over the register map; unmapped offsets read 0.
  always_comb begin
    rd_val = '0;
    case (off)
      TMR_CTRL: begin
        rd_val[CTRL_EN] = en;
        rd_val[CTRL_AR] = ar;
        rd_val[CTRL_IE] = ie;
      end
      TMR_PRESCALE: rd_val[15:0] = prescale;
      TMR_LOAD:     rd_val = load;
      TMR_COUNT:    rd_val = count;
      TMR_STATUS:   rd_val[STATUS_EXP] = exp;
      default:      rd_val = '0;
    endcase
  end

  // Bus handshake, registers and counter. Bus writes are placed after the
  // counter update so they take priority; the expiry set is placed after the
  // W1C so a simultaneous expiry keeps EXP high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      irq         <= 1'b0;
      en          <= 1'b0;
      ar          <= 1'b0;
      ie          <= 1'b0;
      exp         <= 1'b0;
      prescale    <= RESET_PRESCALE;
      load        <= RESET_LOAD;
      count       <= '0;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= rd ? rd_val : '0;
      irq         <= exp & ie;

      if (tick) begin
        if (count != '0) begin
          count <= count - 32'd1;
        end else if (ar) begin
          count <= load;
        end else begin
          en <= 1'b0;
        end
      end

      if (wr && off == TMR_CTRL && iomem_wstrb[0]) begin
        en <= iomem_wdata[CTRL_EN];
        ar <= iomem_wdata[CTRL_AR];
        ie <= iomem_wdata[CTRL_IE];
      end
      if (wr && off == TMR_PRESCALE) prescale <= wd_prescale[15:0];
      if (wr && off == TMR_LOAD)     load     <= wd_load;
      if (wr && off == TMR_COUNT)    count    <= wd_count;

      if (wr && off == TMR_STATUS && iomem_wstrb[0] && iomem_wdata[STATUS_EXP]) exp <= 1'b0;
      if (expire) exp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iomem_timer.sv
// Directed self-checking bench for iomem_timer.
module tb_iomem_timer;

  localparam logic [31:0] A_CTRL     = 32'h0300_0000;
  localparam logic [31:0] A_PRESCALE = 32'h0300_0004;
  localparam logic [31:0] A_LOAD     = 32'h0300_0008;
  localparam logic [31:0] A_COUNT    = 32'h0300_000C;
  localparam logic [31:0] A_STATUS   = 32'h0300_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  iomem_timer #(
    .BASE_ADDR      (32'h0300_0000),
    .RESET_PRESCALE (16'h0000),
    .RESET_LOAD     (32'hFFFF_FFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single write: ready must appear one cycle after valid, for one cycle.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
    @(posedge clk); #1;
    chk("wr_ready", {31'b0, iomem_ready}, 32'd1);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("wr_ready_pulse", {31'b0, iomem_ready}, 32'd0);
  endtask

  // Single read checked against a hand-computed value.
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] expv);
    logic [31:0] d;
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("rd_ready", {31'b0, iomem_ready}, 32'd1);
    d = iomem_rdata;
    iomem_valid = 1'b0;
    @(posedge clk); #1;
    chk("rd_ready_pulse", {31'b0, iomem_ready}, 32'd0);
    chk("rd_idle_data", iomem_rdata, 32'd0);
    chk(tag, d, expv);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_ready", {31'b0, iomem_ready}, 32'd0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_prescale", A_PRESCALE, 32'h0);
    rd_chk("rst_load", A_LOAD, 32'hFFFF_FFFF);
    rd_chk("rst_count", A_COUNT, 32'h0);
    rd_chk("rst_status", A_STATUS, 32'h0);

    // Byte strobes on LOAD
    bus_write(A_LOAD, 32'hAABB_CCDD, 4'b0101);
    rd_chk("strb_load", A_LOAD, 32'hFFBB_FFDD);

    // Outside the window: no ready at all
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0100; iomem_wstrb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("oow_no_ready", {31'b0, iomem_ready}, 32'd0);
    end
    iomem_valid = 1'b0;
    wait_cycles(1);
    // Unmapped offset inside the window
    rd_chk("hole_rdata", 32'h0300_0020, 32'h0);

    // One-shot: 4 ticks from enable to expiry
    bus_write(A_PRESCALE, 32'h0, 4'hF);
    bus_write(A_COUNT, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'h5, 4'hF);            // EN|IE at edge W
    wait_cycles(3);                             // W+4+1
    chk("os_irq_not_yet", {31'b0, irq}, 32'd0);
    wait_cycles(1);                             // W+5+1
    chk("os_irq_rise", {31'b0, irq}, 32'd1);
    rd_chk("os_status", A_STATUS, 32'h1);
    rd_chk("os_ctrl_en_clr", A_CTRL, 32'h4);
    rd_chk("os_count_hold", A_COUNT, 32'h0);
    bus_write(A_STATUS, 32'h1, 4'h1);
    chk("os_irq_drop", {31'b0, irq}, 32'd0);
    rd_chk("os_status_clr", A_STATUS, 32'h0);

    // Auto-reload: PRESCALE=2, LOAD=4 -> 15-cycle period
    do_reset();
    bus_write(A_PRESCALE, 32'd2, 4'hF);
    bus_write(A_LOAD, 32'd4, 4'hF);
    bus_write(A_COUNT, 32'd4, 4'hF);
    bus_write(A_CTRL, 32'h3, 4'hF);             // EN|AR at edge W, ticks at W+3k
    rd_chk("ar_count0", A_COUNT, 32'd4);        // sel W+2
    wait_cycles(1);
    rd_chk("ar_count1", A_COUNT, 32'd3);        // sel W+5
    wait_cycles(1);
    rd_chk("ar_count2", A_COUNT, 32'd2);        // sel W+8
    wait_cycles(1);
    rd_chk("ar_count3", A_COUNT, 32'd1);        // sel W+11
    wait_cycles(1);
    rd_chk("ar_count4", A_COUNT, 32'd0);        // sel W+14
    wait_cycles(1);
    rd_chk("ar_count5", A_COUNT, 32'd4);        // sel W+17, reloaded at W+15
    rd_chk("ar_exp_set", A_STATUS, 32'h1);      // sel W+19
    bus_write(A_STATUS, 32'h1, 4'h1);           // sel W+21
    rd_chk("ar_exp_clr", A_STATUS, 32'h0);      // sel W+23
    wait_cycles(4);
    rd_chk("ar_exp_before", A_STATUS, 32'h0);   // sel W+29
    rd_chk("ar_exp_reset", A_STATUS, 32'h1);    // sel W+31, expiry at W+30
    chk("ar_irq_off", {31'b0, irq}, 32'd0);

    // COUNT write collides with tick at W+33
    bus_write(A_COUNT, 32'h100, 4'hF);
    rd_chk("col_count", A_COUNT, 32'h100);      // sel W+35
    bus_write(A_STATUS, 32'h1, 4'h1);           // sel W+37
    bus_write(A_COUNT, 32'h0, 4'hF);            // sel W+39 (tick, bus wins)
    wait_cycles(1);
    bus_write(A_STATUS, 32'h1, 4'h1);           // sel W+42 with expiry
    rd_chk("col_w1c_exp", A_STATUS, 32'h1);     // sel W+44
    rd_chk("col_reload", A_COUNT, 32'd3);       // sel W+46

    // Async reset in the middle of a write
    iomem_valid = 1'b1; iomem_addr = A_LOAD; iomem_wdata = 32'h1234_5678; iomem_wstrb = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_no_ready", {31'b0, iomem_ready}, 32'd0);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_no_ready2", {31'b0, iomem_ready}, 32'd0);
    chk("arst_irq", {31'b0, irq}, 32'd0);
    rd_chk("arst_ctrl", A_CTRL, 32'h0);
    rd_chk("arst_prescale", A_PRESCALE, 32'h0);
    rd_chk("arst_load", A_LOAD, 32'hFFFF_FFFF);
    rd_chk("arst_count", A_COUNT, 32'h0);
    rd_chk("arst_status", A_STATUS, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
